alu_writeback: RTL

// - Stage directly downstream of the ALU. Accepts one ALU result per valid/ready transfer.
// - Byte ops: merges the result byte into the old destination word.
// - Merges the selected ALU flags into the CPU status register (PSR/SC).
// - Buffers the merged result for the register-file write port.

---
 rtl/alu_writeback.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/alu_writeback.sv
// alu_writeback: write-back stage after the ALU.
// Accepts one ALU result per valid/ready transfer. For byte ops it merges the
// result into the old destination word. It merges the selected ALU flags into
// the PSR and buffers the merged entry for the register-file write port.
// Build option: define ALU_WB_SKID_EN for a 2-entry skid buffer with a
// registered in_ready. Leave it undefined for a single-entry output register.
module alu_writeback #(
   parameter int          DATA_W    = 16,
   parameter logic [7:0]  PSR_RESET = 8'hC0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_result,
   input  logic [5:0]        in_flags,
   input  logic [5:0]        in_flag_mask,
   input  logic              in_size,
   input  logic [DATA_W-1:0] in_dest_old,
   input  logic              in_wb_en,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_wb_en,
   output logic [7:0]        psr,
   input  logic              psr_we,
   input  logic [7:0]        psr_wdata
);

   logic              acc;
   logic              drain;
   logic [DATA_W-1:0] merged_data;
   logic [7:0]        psr_q;
   logic [7:0]        psr_merged;

   // AC and P have no home in the PSR. The low destination byte is always
   // replaced by a byte op.
   logic unused_inputs;
   assign unused_inputs = ^{in_flags[3], in_flags[0], in_flag_mask[3],
                            in_flag_mask[0], in_dest_old[7:0]};

   assign acc   = in_valid & in_ready;
   assign drain = out_valid & out_ready;
   assign psr   = psr_q;

   // Byte op keeps the old upper byte; word op passes the result through.
   always_comb begin
      merged_data = in_result;
      if (!in_size) begin
         merged_data = {in_dest_old[DATA_W-1:8], in_result[7:0]};
      end
   end

   // Flag merge into Z/C/V/N. The upper nibble (D, U, I1:I0) is never touched.
   always_comb begin
      psr_merged = psr_q;
      if (in_flag_mask[5]) psr_merged[0] = in_flags[5];
      if (in_flag_mask[1]) psr_merged[1] = in_flags[1];
      if (in_flag_mask[2]) psr_merged[2] = in_flags[2];
      if (in_flag_mask[4]) psr_merged[3] = in_flags[4];
   end

   // PSR register. A direct write overrides a same-cycle flag merge.
   always_ff @(posedge clk) begin
      if (reset) begin
         psr_q <= PSR_RESET;
      end else if (psr_we) begin
         psr_q <= psr_wdata;
      end else if (acc) begin
         psr_q <= psr_merged;
      end
   end

`ifdef ALU_WB_SKID_EN
   logic              e0_full;
   logic              e1_full;
   logic [DATA_W-1:0] e0_data;
   logic [DATA_W-1:0] e1_data;
   logic              e0_wb;
   logic              e1_wb;

   // in_ready depends only on a flop, so out_ready has no path into it.
   assign in_ready  = ~e1_full;
   assign out_valid = e0_full;
   assign out_data  = e0_data;
   assign out_wb_en = e0_wb;

   // Two-entry skid buffer. e0 is the head. e1 fills only when the head
   // stalls, and in_ready is low while e1 is occupied, so no accept happens then.
   always_ff @(posedge clk) begin
      if (reset) begin
         e0_full <= 1'b0;
         e1_full <= 1'b0;
         e0_data <= '0;
         e1_data <= '0;
         e0_wb   <= 1'b0;
         e1_wb   <= 1'b0;
      end else if (e1_full) begin
         if (drain) begin
            e0_data <= e1_data;
            e0_wb   <= e1_wb;
            e1_full <= 1'b0;
         end
      end else if (e0_full) begin
         if (acc && drain) begin
            e0_data <= merged_data;
            e0_wb   <= in_wb_en;
         end else if (acc) begin
            e1_data <= merged_data;
            e1_wb   <= in_wb_en;
            e1_full <= 1'b1;
         end else if (drain) begin
            e0_full <= 1'b0;
         end
      end else if (acc) begin
         e0_data <= merged_data;
         e0_wb   <= in_wb_en;
         e0_full <= 1'b1;
      end
   end
`else
   logic              e0_full;
   logic [DATA_W-1:0] e0_data;
   logic              e0_wb;

   assign in_ready  = ~e0_full | out_ready;
   assign out_valid = e0_full;
   assign out_data  = e0_data;
   assign out_wb_en = e0_wb;

   // Single output register. An accept in the same cycle as a drain replaces the entry.
   always_ff @(posedge clk) begin
      if (reset) begin
         e0_full <= 1'b0;
         e0_data <= '0;
         e0_wb   <= 1'b0;
      end else if (acc) begin
         e0_data <= merged_data;
         e0_wb   <= in_wb_en;
         e0_full <= 1'b1;
      end else if (drain) begin
         e0_full <= 1'b0;
      end
   end
`endif

endmodule
